// File: rtl/dmem_access_sequencer_if.sv
// Request, SRAM and status signals between the MEM stage,
// the data-memory sequencer and the SRAM macro.
interface dmem_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ReqREB;
  logic              ReqWEB;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWdata;
  logic              MemCEB;
  logic              MemWEB;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic [DATA_W-1:0] Rdata;
  logic              Stall;
  logic              Done;
  logic              Error;

  modport master (
    output ReqREB, ReqWEB, ReqAddr, ReqWdata, MemRdata,
    input  MemCEB, MemWEB, MemAddr, MemWdata,
    input  Rdata, Stall, Done, Error
  );

  modport slave (
    input  ReqREB, ReqWEB, ReqAddr, ReqWdata, MemRdata,
    output MemCEB, MemWEB, MemAddr, MemWdata,
    output Rdata, Stall, Done, Error
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Sequences MEM-stage loads/stores onto a single-ported
// synchronous SRAM with fixed wait states, freezing the pipeline.
module dmem_access_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic CLK,
  input logic RSTB,
  dmem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              is_wr, is_wr_d;
  logic              ceb, ceb_d;
  logic              web, web_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] wdata, wdata_d;
  logic [DATA_W-1:0] rdata, rdata_d;
  logic              done, done_d;
  logic              error, error_d;
  logic              req_valid;
  logic              req_illegal;

  assign req_valid   = bus.ReqREB ^ bus.ReqWEB;
  assign req_illegal = ~bus.ReqREB & ~bus.ReqWEB;

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
      ceb   <= 1'b1;
      web   <= 1'b1;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      is_wr <= is_wr_d;
      ceb   <= ceb_d;
      web   <= web_d;
      addr  <= addr_d;
      wdata <= wdata_d;
      rdata <= rdata_d;
      done  <= done_d;
      error <= error_d;
    end
  end

  // SRAM strobes are set up one edge ahead of the state they belong to
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    is_wr_d = is_wr;
    ceb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = addr;
    wdata_d = wdata;
    rdata_d = rdata;
    done_d  = 1'b0;
    error_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d  = bus.ReqAddr;
          wdata_d = bus.ReqWdata;
          is_wr_d = ~bus.ReqWEB;
          ceb_d   = 1'b0;
          web_d   = bus.ReqWEB;
          state_d = ACCESS;
        end else if (req_illegal) begin
          error_d = 1'b1;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!is_wr) rdata_d = bus.MemRdata;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Stall = RSTB & ((state == IDLE & req_valid) |
                             state == ACCESS | state == WAIT);

  assign bus.MemCEB   = ceb;
  assign bus.MemWEB   = web;
  assign bus.MemAddr  = addr;
  assign bus.MemWdata = wdata;
  assign bus.Rdata    = rdata;
  assign bus.Done     = done;
  assign bus.Error    = error;

endmodule

// File: doc/dmem_access_sequencer.md
# dmem_access_sequencer

Sequences every data-memory access issued by the EX/MEM stage onto a single-ported synchronous SRAM with a configurable number of wait states. It freezes the pipeline for the duration of the access and returns read data in a holding register. It sits between the pipeline's active-low memory request signals (REB/WEB, as produced by the ID/EX control unit) and the SRAM macro. It owns the SRAM chip-enable and write-enable and is the only master of that resource.

## Interface
Parameters:
- ADDR_W, 32, width of request and SRAM address.
- DATA_W, 32, width of write data and read data.
- WAIT_CYCLES, 1, number of wait cycles after the enable cycle, legal range 1..15.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RSTB  in  1  synchronous reset, active-low.
- ReqREB  in  1  active-low read request from the MEM stage.
- ReqWEB  in  1  active-low write request from the MEM stage.
- ReqAddr  in  ADDR_W  byte address of the request.
- ReqWdata  in  DATA_W  store data.
- MemCEB  out  1  SRAM chip enable, active-low, registered.
- MemWEB  out  1  SRAM write enable, active-low, registered.
- MemAddr  out  ADDR_W  SRAM address, registered.
- MemWdata  out  DATA_W  SRAM write data, registered.
- MemRdata  in  DATA_W  SRAM read data.
- Rdata  out  DATA_W  captured load data, registered.
- Stall  out  1  pipeline freeze, combinational.
- Done  out  1  one-cycle pulse on access completion, registered.
- Error  out  1  one-cycle pulse on an illegal request, registered.

## Operation
- Valid request: exactly one of ReqREB/ReqWEB low. Illegal request: both low.
- FSM states are IDLE, ACCESS, WAIT and DONE. A 4-bit wait counter is used.
- IDLE:
  - On a valid request, latch ReqAddr and ReqWdata into MemAddr/MemWdata and latch the access type. Go to ACCESS.
  - On an illegal request, pulse Error next cycle. No access. Stay in IDLE.
  - With no request, stay in IDLE.
- ACCESS (1 cycle):
  - MemCEB=0. MemWEB=0 for a write, 1 for a read.
  - Load counter with WAIT_CYCLES-1. Go to WAIT.
- WAIT:
  - MemCEB=1 and MemWEB=1. Decrement the counter.
  - When the counter is 0, go to DONE. For a read, capture MemRdata into Rdata on that same edge.
- DONE (1 cycle):
  - Done=1. Requests are ignored, because the inputs still belong to the completed instruction. Go to IDLE.
- Stall = RSTB & ((IDLE & valid request) | ACCESS | WAIT). Stall is 0 in DONE and during an illegal request.
- Rdata changes only on read completion. Writes leave Rdata unchanged.
- Request inputs are sampled only in IDLE. Changes during ACCESS/WAIT/DONE have no effect.

## Timing
- Reset values (edge with RSTB=0): state IDLE, MemCEB=1, MemWEB=1, MemAddr=0, MemWdata=0, Rdata=0, Done=0, Error=0, counter=0. Stall is forced 0 while RSTB=0.
- Reset mid-access aborts the access. The SRAM sees CEB=1 from the next cycle, and no Done pulse occurs.
- Request first seen in IDLE at cycle 0, with W = WAIT_CYCLES:
  - ACCESS at cycle 1.
  - WAIT at cycles 2..W+1.
  - DONE at cycle W+2, with Done=1 and Rdata valid.
- Stall is high for cycles 0..W+1, which is W+2 cycles. Stall is low at cycle W+2, so the pipeline advances at the end of the DONE cycle.
- The SRAM must present read data at or before the edge ending the last WAIT cycle. That is W cycles after the enable edge.
- Back-to-back memory instructions: the next request is seen in IDLE at cycle W+3. Minimum spacing between enable cycles is W+3 cycles.
- Error asserts one cycle after an illegal request. It repeats every cycle the illegal request is held in IDLE.

## Test plan
- Reset: hold RSTB=0 for 3 cycles with ReqREB=0.
  - Stall=0, MemCEB=1, MemWEB=1, Rdata=0, Done=0 throughout.
- Read, W=2: ReqREB=0, ReqAddr=0x0000_0040; SRAM returns 0xDEAD_BEEF.
  - MemCEB=0 and MemWEB=1 only at cycle 1, with MemAddr=0x40.
  - Stall high cycles 0..3.
  - Done and Rdata=0xDEAD_BEEF at cycle 4.
- Write, W=2: ReqWEB=0, ReqAddr=0x44, ReqWdata=0x1234_5678.
  - MemCEB=0, MemWEB=0, MemWdata=0x1234_5678 at cycle 1.
  - Done at cycle 4. Rdata keeps its previous value.
- Back-to-back: a read at 0x40 followed immediately by a write at 0x48.
  - Exactly two enable cycles, at cycles 1 and 6.
  - No duplicate access during DONE. Two Done pulses, at cycles 4 and 9.
- Illegal request: ReqREB=0 and ReqWEB=0 for 2 cycles.
  - Error high cycles 1..2. MemCEB stays 1. Stall stays 0.
- Reset mid-access: RSTB=0 at cycle 2 of a W=3 read.
  - State returns to IDLE. No Done pulse. Rdata=0.
  - A read issued after reset completes normally, with Done at cycle 5.
